// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between instruction
//               fetch and load/store, with stall generation and a wait-cycle
//               watchdog. Optional macro ARB_PERF_CNT_EN adds stall counters.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_dm_stall,
`endif
    output logic              err
);

    localparam int                  c_WAIT_W    = 8;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t              r_state,     w_state;
    logic [c_WAIT_W-1:0] r_wait_cnt,  w_wait_cnt;
    logic                r_mem_req,   w_mem_req;
    logic                r_mem_we,    w_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;
    logic                r_if_ack,    w_if_ack;
    logic                r_dm_ack,    w_dm_ack;
    logic [DATA_W-1:0]   r_if_rdata,  w_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata,  w_dm_rdata;
    logic                r_err,       w_err;
    logic                w_dm_elig;
    logic                w_if_elig;

    // A port acked this cycle still shows its old address, so it sits out one grant.
    assign w_dm_elig = dm_req & ~r_dm_ack;
    assign w_if_elig = if_req & ~r_if_ack;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_wait_cnt  <= w_wait_cnt;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_if_ack    <= w_if_ack;
            r_dm_ack    <= w_dm_ack;
            r_if_rdata  <= w_if_rdata;
            r_dm_rdata  <= w_dm_rdata;
            r_err       <= w_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_wait_cnt  = r_wait_cnt;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_if_ack    = 1'b0;
        w_dm_ack    = 1'b0;
        w_if_rdata  = r_if_rdata;
        w_dm_rdata  = r_dm_rdata;
        w_err       = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_dm_elig) begin
                    w_state     = S_DATA;
                    w_wait_cnt  = '0;
                    w_mem_req   = 1'b1;
                    w_mem_we    = dm_we;
                    w_mem_addr  = dm_addr;
                    w_mem_wdata = dm_wdata;
                end else if (w_if_elig) begin
                    w_state     = S_FETCH;
                    w_wait_cnt  = '0;
                    w_mem_req   = 1'b1;
                    w_mem_we    = 1'b0;
                    w_mem_addr  = if_addr;
                end else begin
                    w_mem_req   = 1'b0;
                end
            end
            S_FETCH, S_DATA: begin
                if (mem_ready) begin
                    w_state   = S_IDLE;
                    w_mem_req = 1'b0;
                    if (r_state == S_FETCH) begin
                        w_if_rdata = mem_rdata;
                        w_if_ack   = 1'b1;
                    end else begin
                        w_dm_rdata = mem_rdata;
                        w_dm_ack   = 1'b1;
                    end
                end else begin
                    w_wait_cnt = r_wait_cnt + 8'd1;
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        w_state   = S_ERR;
                        w_mem_req = 1'b0;
                        w_err     = 1'b1;
                    end
                end
            end
            S_ERR: begin
                w_mem_req = 1'b0;
                w_err     = 1'b1;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);

    assign stall_mem = (dm_req & ~r_dm_ack) | r_err;
    assign stall_if  = (if_req & ~r_if_ack) | stall_mem;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_if;
    logic [31:0] r_perf_dm;

    // Saturating counters: they hold at all-ones rather than wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_if <= '0;
            r_perf_dm <= '0;
        end else begin
            if (stall_if && (r_perf_if != 32'hFFFF_FFFF)) begin
                r_perf_if <= r_perf_if + 32'd1;
            end
            if (stall_mem && (r_perf_dm != 32'hFFFF_FFFF)) begin
                r_perf_dm <= r_perf_dm + 32'd1;
            end
        end
    end

    assign perf_if_stall = r_perf_if;
    assign perf_dm_stall = r_perf_dm;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a simple memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;
    logic        err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_dm_stall;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .busy      (busy),
`ifdef ARB_PERF_CNT_EN
        .perf_if_stall (perf_if_stall),
        .perf_dm_stall (perf_dm_stall),
`endif
        .err       (err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } rd_exp_t;

    mem_exp_t    exp_mem[$];
    logic [31:0] exp_if[$];
    rd_exp_t     exp_dm[$];
    logic [31:0] mem_img [logic [31:0]];

    int total = 0;
    int bad   = 0;
    int cfg_waits = 0;
    int wctr = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got unexpected event want none at %0t", nm, $time);
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (2) @(negedge clock);
        exp_mem.delete();
        exp_if.delete();
        exp_dm.delete();
        reset = 1'b1;
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
        mem_exp_t e;
        e.we = we; e.addr = a; e.wdata = d;
        exp_mem.push_back(e);
    endtask

    task automatic push_dm(input logic c, input logic [31:0] d);
        rd_exp_t e;
        e.chk = c; e.data = d;
        exp_dm.push_back(e);
    endtask

    // Memory model: answers after cfg_waits wait cycles, stores update the image.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (reset && mem_req) begin
                if (wctr == cfg_waits) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem_img[mem_addr] = mem_wdata;
                        mem_rdata = 32'h0BAD_0BAD;
                    end else begin
                        mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'h0;
                    end
                end else begin
                    mem_ready = 1'b0;
                    wctr++;
                end
            end else begin
                mem_ready = 1'b0;
                wctr = 0;
            end
        end
    end

    // Monitor: compares every memory request cycle and every ack against the queues.
    initial begin
        mem_exp_t me;
        rd_exp_t  de;
        logic [31:0] ie;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                if (mem_req) begin
                    if (exp_mem.size() == 0) begin
                        unexpected("mem_req");
                    end else begin
                        me = exp_mem[0];
                        chk("mem_we", {31'd0, mem_we}, {31'd0, me.we});
                        chk("mem_addr", mem_addr, me.addr);
                        if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
                        if (mem_ready) void'(exp_mem.pop_front());
                    end
                end
                if (if_ack) begin
                    if (exp_if.size() == 0) begin
                        unexpected("if_ack");
                    end else begin
                        ie = exp_if.pop_front();
                        chk("if_rdata", if_rdata, ie);
                    end
                end
                if (dm_ack) begin
                    if (exp_dm.size() == 0) begin
                        unexpected("dm_ack");
                    end else begin
                        de = exp_dm.pop_front();
                        if (de.chk) chk("dm_rdata", dm_rdata, de.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        mem_img[32'h40] = 32'h8C22_0004;
        mem_img[32'h20] = 32'h1234_5678;

        // Reset state
        cyc(); #3;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rst_dm_ack", {31'd0, dm_ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        cyc(); reset = 1'b1;

        // Fetch only, zero wait states
        cyc();
        if_req = 1'b1; if_addr = 32'h40;
        push_mem(1'b0, 32'h40, 32'h0); exp_if.push_back(32'h8C22_0004);
        #3; chk("f_stall_c0", {31'd0, stall_if}, 32'd1);
        cyc(); #3;
        chk("f_mem_req_c1", {31'd0, mem_req}, 32'd1);
        chk("f_stall_c1", {31'd0, stall_if}, 32'd1);
        chk("f_busy_c1", {31'd0, busy}, 32'd1);
        chk("f_ack_c1", {31'd0, if_ack}, 32'd0);
        cyc(); #3;
        chk("f_ack_c2", {31'd0, if_ack}, 32'd1);
        chk("f_mem_req_c2", {31'd0, mem_req}, 32'd0);
        chk("f_stall_c2", {31'd0, stall_if}, 32'd0);
        cyc(); if_req = 1'b0; #3;
        chk("f_ack_c3", {31'd0, if_ack}, 32'd0);
        chk("f_busy_c3", {31'd0, busy}, 32'd0);

        // Simultaneous store and fetch: data first, fetch granted in dm_ack cycle
        cyc();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h40;
        push_mem(1'b1, 32'h100, 32'hDEAD_BEEF); push_mem(1'b0, 32'h40, 32'h0);
        push_dm(1'b0, 32'h0); exp_if.push_back(32'h8C22_0004);
        cyc(); #3;
        chk("b_mem_we_c1", {31'd0, mem_we}, 32'd1);
        chk("b_stall_mem_c1", {31'd0, stall_mem}, 32'd1);
        chk("b_stall_if_c1", {31'd0, stall_if}, 32'd1);
        cyc(); #3;
        chk("b_dm_ack_c2", {31'd0, dm_ack}, 32'd1);
        chk("b_mem_req_c2", {31'd0, mem_req}, 32'd0);
        chk("b_stall_mem_c2", {31'd0, stall_mem}, 32'd0);
        chk("b_stall_if_c2", {31'd0, stall_if}, 32'd1);
        cyc(); dm_req = 1'b0; #3;
        chk("b_mem_req_c3", {31'd0, mem_req}, 32'd1);
        chk("b_mem_addr_c3", mem_addr, 32'h40);
        chk("b_if_ack_c3", {31'd0, if_ack}, 32'd0);
        cyc(); #3;
        chk("b_if_ack_c4", {31'd0, if_ack}, 32'd1);
        chk("b_stall_if_c4", {31'd0, stall_if}, 32'd0);
        cyc(); if_req = 1'b0;
        chk("b_store_written", mem_img[32'h100], 32'hDEAD_BEEF);

        // Load with 3 wait states; address change mid-access must be ignored
        cfg_waits = 3;
        do_reset();
        cyc();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        push_mem(1'b0, 32'h20, 32'h0); push_dm(1'b1, 32'h1234_5678);
        #3; chk("l_stall_c0", {31'd0, stall_mem}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 2) dm_addr = 32'h24;
            #3;
            chk("l_mem_req", {31'd0, mem_req}, 32'd1);
            chk("l_dm_ack_early", {31'd0, dm_ack}, 32'd0);
            chk("l_stall_mem", {31'd0, stall_mem}, 32'd1);
        end
        cyc(); #3;
        chk("l_dm_ack", {31'd0, dm_ack}, 32'd1);
        chk("l_mem_req_end", {31'd0, mem_req}, 32'd0);
        chk("l_stall_end", {31'd0, stall_mem}, 32'd0);
`ifdef ARB_PERF_CNT_EN
        chk("perf_dm_stall", perf_dm_stall, 32'd5);
        chk("perf_if_stall", perf_if_stall, 32'd5);
`endif
        cyc(); dm_req = 1'b0; dm_addr = 32'h20;

        // Timeout: memory never answers
        cfg_waits = 1000;
        cyc();
        if_req = 1'b1; if_addr = 32'h80;
        push_mem(1'b0, 32'h80, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            cyc(); #3;
            chk("t_mem_req_wait", {31'd0, mem_req}, 32'd1);
            chk("t_err_early", {31'd0, err}, 32'd0);
        end
        cyc(); #3;
        chk("t_err", {31'd0, err}, 32'd1);
        chk("t_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t_stall_if", {31'd0, stall_if}, 32'd1);
        chk("t_stall_mem", {31'd0, stall_mem}, 32'd1);
        chk("t_busy", {31'd0, busy}, 32'd1);
        exp_mem.delete();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        for (int k = 0; k < 5; k++) begin
            cyc(); #3;
            chk("t_no_grant", {31'd0, mem_req}, 32'd0);
            chk("t_err_sticky", {31'd0, err}, 32'd1);
            chk("t_no_ack", {30'd0, if_ack, dm_ack}, 32'd0);
        end

        // Asynchronous reset on the 2nd wait cycle of a data access
        do_reset();
        cfg_waits = 5;
        chk("r_err_cleared", {31'd0, err}, 32'd0);
        cyc();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        push_mem(1'b0, 32'h20, 32'h0);
        cyc(); #3;
        chk("r_mem_req_c1", {31'd0, mem_req}, 32'd1);
        cyc(); #1;
        reset = 1'b0;
        exp_mem.delete();
        #1;
        chk("r_async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("r_async_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("r_async_err", {31'd0, err}, 32'd0);
        chk("r_async_busy", {31'd0, busy}, 32'd0);
        chk("r_async_addr", mem_addr, 32'd0);
        cyc(); dm_req = 1'b0;
        cyc(); reset = 1'b1; cfg_waits = 0;
        cyc();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        push_mem(1'b0, 32'h20, 32'h0); push_dm(1'b1, 32'h1234_5678);
        cyc(); #3;
        chk("r_post_mem_req", {31'd0, mem_req}, 32'd1);
        cyc(); #3;
        chk("r_post_dm_ack", {31'd0, dm_ack}, 32'd1);
        chk("r_post_dm_rdata", dm_rdata, 32'h1234_5678);
        cyc(); dm_req = 1'b0;
        repeat (3) cyc();

        chk("left_mem", exp_mem.size(), 32'd0);
        chk("left_if", exp_if.size(), 32'd0);
        chk("left_dm", exp_dm.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates a single shared, variable-latency memory port between the IF-stage instruction fetch and the MEM-stage load/store.
- Generates per-stage stall signals for the hazard/PC-write logic.
- Sits between the pipeline (PC/IF_ID and EX_MEM/MEM_WB) and a unified memory, replacing the separate instruction and data memories.
- Includes a wait-cycle timeout watchdog with a sticky error.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MAX_WAIT, 15, maximum cycles mem_req may stay high without mem_ready before error (1..255).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction; valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request (EX_MEM MemRead|MemWrite); held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid when dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for data.
- mem_req  out  1  shared-memory request, held until mem_ready.
- mem_we  out  1  shared-memory write enable.
- mem_addr  out  ADDR_W  shared-memory address.
- mem_wdata  out  DATA_W  shared-memory write data.
- mem_rdata  in  DATA_W  shared-memory read data; valid with mem_ready.
- mem_ready  in  1  shared-memory completion, sampled only while mem_req=1.
- stall_if  out  1  freeze PC and IF_ID.
- stall_mem  out  1  freeze the whole pipeline.
- busy  out  1  state is not IDLE.
- err  out  1  sticky timeout error.

Behaviour:

States:
- IDLE, FETCH, DATA, ERR.
- On reset assertion: state=IDLE, wait counter=0, and every registered output is 0 (mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, err). This takes effect immediately, mid-transaction included; an in-flight memory access is abandoned.

IDLE:
- Grant on the clock edge. dm_req has priority over if_req, because the older instruction goes first.
- A port that was acked in the current cycle is masked for that cycle, since its address is still stale.
- DATA grant: register dm_addr/dm_we/dm_wdata onto mem_addr/mem_we/mem_wdata, set mem_req=1, go to DATA.
- FETCH grant: register if_addr onto mem_addr, set mem_we=0, set mem_req=1, go to FETCH.
- No eligible request: remain in IDLE with mem_req=0.

FETCH / DATA:
- mem_addr, mem_we and mem_wdata are held stable while mem_req=1.
- On a cycle with mem_ready=1:
  - Register mem_rdata into if_rdata (FETCH) or dm_rdata (DATA). dm_rdata is updated on stores too, with don't-care content.
  - Pulse if_ack or dm_ack for exactly the next cycle.
  - Drop mem_req and return to IDLE.
- Otherwise the wait counter increments.
  - The counter reaching MAX_WAIT with mem_ready=0 goes to ERR: mem_req=0, err=1.
  - The counter clears on every grant.

ERR:
- Absorbing until reset; no grants and no acks.

Latency:
- Minimum is req sampled in cycle 0, mem_req in cycle 1, mem_ready in cycle 1, ack in cycle 2.
- Each added wait state adds one cycle.

Requesters:
- Dropping a req before its ack does not abort the access. The ack still pulses and is ignored.
- Changing the address while req is held is ignored until the next grant.

Stall outputs (combinational):
- stall_if = (if_req & ~if_ack) | stall_mem | err.
- stall_mem = (dm_req & ~dm_ack) | err.

Simultaneous events:
- Both requests in IDLE: DATA first, then FETCH is granted in the dm_ack cycle (dm masked), giving no starvation of fetch.
- mem_ready while in IDLE or ERR is ignored.

busy:
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_if_stall: 32-bit count of cycles with stall_if=1.
  - perf_dm_stall: 32-bit count of cycles with stall_mem=1.
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Fetch only, if_addr=0x00000040, mem_ready in the same cycle as mem_req, mem_rdata=0x8C220004 -> mem_addr=0x40, mem_we=0; if_ack=1 and if_rdata=0x8C220004 two cycles after req; stall_if=1 for exactly 2 cycles.
- if_req and dm_req (store, dm_addr=0x100, dm_wdata=0xDEADBEEF) in the same cycle, ready with 0 waits -> first access is mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; dm_ack; fetch granted in the dm_ack cycle; if_ack 2 cycles later.
- Load dm_addr=0x20 with 3 wait states, mem_rdata=0x12345678 -> mem_req high for 4 cycles with stable address; dm_ack one cycle after mem_ready; dm_rdata=0x12345678; stall_mem=1 throughout.
- mem_ready never asserted, MAX_WAIT=15 -> err=1 after 15 wait cycles; mem_req=0; stall_if=stall_mem=1; no further grants until reset.
- Reset driven low mid-DATA on the 2nd wait cycle -> mem_req, acks and err go to 0 immediately without a clock edge; after release, the first request completes normally.
- With ARB_PERF_CNT_EN, the run of scenario 3 -> perf_dm_stall=5 and perf_if_stall=5 (stall_if includes stall_mem).
